// File: rtl/ext_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ext_mem_arbiter_pkg
//  Purpose  : Shared memory-system constants for the external memory arbiter:
//             state and owner encodings, default tuning values and the
//             arbitration helper used in the IDLE state.
//  Revision : 1.0 - initial release
// ============================================================================
package ext_mem_arbiter_pkg;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Which requester owns the external port
    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    // Default tuning values
    localparam int DEF_D_STREAK_MAX   = 4;
    localparam int DEF_TIMEOUT_CYCLES = 64;

    // Counter widths
    localparam int STREAK_W = 4;
    localparam int TMO_W    = 8;

    // Data side wins unless the instruction side is waiting and the data side
    // has already used up its allowance of consecutive grants.
    function automatic owner_t pick_owner(
        input logic                ireq,
        input logic                dreq,
        input logic [STREAK_W-1:0] streak,
        input logic [STREAK_W-1:0] limit
    );
        if (dreq && (!ireq || (streak < limit))) begin
            return OWN_D;
        end
        return OWN_I;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ext_mem_arbiter_timeout.sv
`default_nettype none
// ============================================================================
//  Module   : mem_timeout_counter
//  Purpose  : 8-bit saturating cycle counter that watches a BUSY state and
//             flags expiry when LIMIT-1 cycles have elapsed since load.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_timeout_counter
    import ext_mem_arbiter_pkg::*;
#(
    parameter int LIMIT = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic enable,
    output logic expired
);

    localparam logic [TMO_W-1:0] LAST_COUNT = TMO_W'(LIMIT - 1);
    localparam logic [TMO_W-1:0] SAT_COUNT  = {TMO_W{1'b1}};

    logic [TMO_W-1:0] count;

    // Load clears the count; enable advances it and it parks at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (enable && (count != SAT_COUNT)) begin
            count <= count + TMO_W'(1);
        end
    end

    // Expiry is seen on the edge that would complete the LIMIT-th busy cycle.
    assign expired = (count == LAST_COUNT);

endmodule
`default_nettype wire

// File: rtl/ext_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ext_mem_arbiter
//  Purpose  : Shares the single external memory port between the instruction
//             refill path and the data load/store path. Registered
//             request/ack handshake, fixed data priority with an instruction
//             starvation guard, and a response timeout that aborts a stalled
//             transfer with a bus_error pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module ext_mem_arbiter
    import ext_mem_arbiter_pkg::*;
#(
    parameter int WORD_SIZE      = 32,
    parameter int D_STREAK_MAX   = DEF_D_STREAK_MAX,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 i_req,
    input  logic [31:0]          i_addr,
    output logic                 i_ack,
    output logic [WORD_SIZE-1:0] i_rdata,

    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [31:0]          d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic                 d_ack,
    output logic [WORD_SIZE-1:0] d_rdata,

    output logic [31:0]          mem_addr,
    output logic [WORD_SIZE-1:0] data_in,
    input  logic [WORD_SIZE-1:0] data_out,
    output logic                 en_ext_mem_re,
    output logic                 en_ext_mem_wr,
    input  logic                 mem_ready,

    output logic                 bus_error,
    output logic                 busy
);

    localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(D_STREAK_MAX);

    state_t              state;
    logic [STREAK_W-1:0] streak;
    logic                we;
    logic                tmo_expired;
    logic                in_busy;
    owner_t              winner;

    assign in_busy = (state == ST_BUSY_I) || (state == ST_BUSY_D);
    assign winner  = pick_owner(i_req, d_req, streak, STREAK_LIMIT);

    // Counter is held cleared while idle so it starts at zero on BUSY entry.
    mem_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .load    (state == ST_IDLE),
        .enable  (in_busy),
        .expired (tmo_expired)
    );

    // Arbitration, transfer sequencing and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            streak        <= '0;
            we            <= 1'b0;
            i_ack         <= 1'b0;
            i_rdata       <= '0;
            d_ack         <= 1'b0;
            d_rdata       <= '0;
            mem_addr      <= '0;
            data_in       <= '0;
            en_ext_mem_re <= 1'b0;
            en_ext_mem_wr <= 1'b0;
            bus_error     <= 1'b0;
            busy          <= 1'b0;
        end else begin
            // Completion pulses last exactly one cycle.
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            bus_error <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (i_req || d_req) begin
                        busy <= 1'b1;
                        if (winner == OWN_D) begin
                            state         <= ST_BUSY_D;
                            mem_addr      <= d_addr;
                            data_in       <= d_wdata;
                            we            <= d_we;
                            en_ext_mem_re <= ~d_we;
                            en_ext_mem_wr <= d_we;
                            // Only grants that overtake a waiting fetch count.
                            streak        <= i_req ? (streak + STREAK_W'(1)) : '0;
                        end else begin
                            state         <= ST_BUSY_I;
                            mem_addr      <= i_addr;
                            data_in       <= '0;
                            we            <= 1'b0;
                            en_ext_mem_re <= 1'b1;
                            en_ext_mem_wr <= 1'b0;
                            streak        <= '0;
                        end
                    end else begin
                        streak <= '0;
                    end
                end

                ST_BUSY_I, ST_BUSY_D: begin
                    // A response on the final count still completes normally.
                    if (mem_ready || tmo_expired) begin
                        state         <= ST_DONE;
                        en_ext_mem_re <= 1'b0;
                        en_ext_mem_wr <= 1'b0;
                        bus_error     <= ~mem_ready;
                        if (state == ST_BUSY_I) begin
                            i_ack   <= 1'b1;
                            i_rdata <= mem_ready ? data_out : '0;
                        end else begin
                            d_ack   <= 1'b1;
                            d_rdata <= (mem_ready && !we) ? data_out : '0;
                        end
                    end
                end

                ST_DONE: begin
                    // Requests are not looked at here; the requester is
                    // dropping its line in response to the ack.
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
